// File: rtl/mo_adder_pkg.sv
// Shared types and constants for the multi-operand adder datapath
// (serial accumulator and binary-tree adder stages).
package mo_adder_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NUM_OPS = 4;

    // Ceiling log2; clog2(1) == 0. Used only in constant expressions.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (rem > 0) begin
                result = result + 1;
                rem    = rem >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell shared by the ripple and tree adders.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_nbit.sv
// N-bit carry-ripple adder: full-adder cells chained carry-to-carry.
module rca_nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         C0,
    output logic [N-1:0] Sum,
    output logic         Carry
);

    logic [N:0] carry_chain;

    assign carry_chain[0] = C0;
    assign Carry          = carry_chain[N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fa
            full_adder u_fa (
                .a    (A[gi]),
                .b    (B[gi]),
                .cin  (carry_chain[gi]),
                .sum  (Sum[gi]),
                .cout (carry_chain[gi+1])
            );
        end
    endgenerate

endmodule

// File: rtl/mo_accumulator.sv
// Serial multi-operand accumulator: sums up to NUM_OPS operands per frame
// and hands the frame sum downstream over a valid/ready handshake.
module mo_accumulator
    import mo_adder_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_OPS = DEF_NUM_OPS
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WIDTH-1:0]                     in_data,
    input  logic                                 in_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WIDTH+clog2(NUM_OPS)-1:0]      out_sum,
    output logic [clog2(NUM_OPS+1)-1:0]          out_count
);

    localparam int SUM_W = WIDTH + clog2(NUM_OPS);
    localparam int CNT_W = clog2(NUM_OPS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_q, state_d;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SUM_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;

    logic [SUM_W-1:0]   operand_ext;
    logic [SUM_W-1:0]   add_sum;
    logic               unused_carry;

    // SUM_W > WIDTH always holds because NUM_OPS >= 2.
    assign operand_ext = {{(SUM_W-WIDTH){1'b0}}, in_data};

    rca_nbit #(
        .N (SUM_W)
    ) u_rca (
        .A     (acc_q),
        .B     (operand_ext),
        .C0    (1'b0),
        .Sum   (add_sum),
        .Carry (unused_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        in_ready    = (state_q == ACCUM);
        out_valid   = (state_q == HOLD);

        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    if (in_last || (cnt_q == LAST_CNT)) begin
                        // Frame end: publish and restart the accumulator in one edge.
                        out_sum_d   = add_sum;
                        out_count_d = cnt_q + CNT_ONE;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = HOLD;
                    end else begin
                        acc_d = add_sum;
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_mo_accumulator.sv
// Directed scoreboard bench for mo_accumulator (WIDTH=8, NUM_OPS=4).
module tb_mo_accumulator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_sum;
    logic [2:0] out_count;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_sum_q[$];
    int exp_cnt_q[$];

    mo_accumulator #(
        .WIDTH   (8),
        .NUM_OPS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
            $display("check %-16s got %0d expected %0d ok", name, act, exp);
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every result handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_sum_q.size() == 0) begin
                check("unexpected_out", int'(out_sum), -1);
            end else begin
                check("frame_sum", int'(out_sum), exp_sum_q.pop_front());
                check("frame_count", int'(out_count), exp_cnt_q.pop_front());
            end
        end
    end

    task automatic expect_frame(input int sum, input int cnt);
        exp_sum_q.push_back(sum);
        exp_cnt_q.push_back(cnt);
    endtask

    // Present one operand and hold it until accepted (bounded wait).
    task automatic send(input int data, input logic last);
        int tries;
        in_valid = 1'b1;
        in_data  = 8'(data);
        in_last  = last;
        tries    = 0;
        while (!in_ready && tries < 50) begin
            @(posedge clk);
            #1;
            tries++;
        end
        if (!in_ready) check("send_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_last  = 1'b1;  // must be ignored without in_valid
        @(posedge clk);
        #1;
        in_last  = 1'b0;
    endtask

    initial begin
        int wait_cycles;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // 1. Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sum", int'(out_sum), 0);
        check("rst_out_count", int'(out_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);

        // Async reset while HOLDing an unconsumed result
        send(3, 1'b0);
        send(3, 1'b1);
        check("pre_arst_valid", int'(out_valid), 1);
        check("pre_arst_sum", int'(out_sum), 6);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_out_sum", int'(out_sum), 0);
        check("arst_out_count", int'(out_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 2. Full frame
        out_ready = 1'b1;
        expect_frame(10, 4);
        send(1, 1'b0);
        send(2, 1'b0);
        send(3, 1'b0);
        send(4, 1'b0);
        check("full_out_valid", int'(out_valid), 1);
        check("full_out_sum", int'(out_sum), 10);
        check("full_out_count", int'(out_count), 4);
        check("full_in_ready0", int'(in_ready), 0);
        @(posedge clk);
        #1;
        check("full_in_ready1", int'(in_ready), 1);
        check("full_valid_drop", int'(out_valid), 0);

        // 3. Maximum operands
        expect_frame(1020, 4);
        for (int i = 0; i < 4; i++) send(255, 1'b0);

        // 4. Short frames
        expect_frame(256, 2);
        send(8'h80, 1'b0);
        send(8'h80, 1'b1);
        expect_frame(7, 1);
        send(7, 1'b1);

        // 5. Backpressure
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        expect_frame(4, 4);
        for (int i = 0; i < 4; i++) send(1, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'd9;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_sum", int'(out_sum), 4);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        expect_frame(36, 4);
        for (int i = 0; i < 4; i++) send(9, 1'b0);

        // 6. Reset mid-frame, then a frame with gaps
        @(posedge clk);
        #1;
        send(50, 1'b0);
        send(60, 1'b0);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_frame(20, 4);
        send(5, 1'b0);
        idle_cycle();
        send(5, 1'b0);
        send(5, 1'b0);
        idle_cycle();
        send(5, 1'b0);

        wait_cycles = 0;
        while (exp_sum_q.size() != 0 && wait_cycles < 20) begin
            @(posedge clk);
            #1;
            wait_cycles++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_sum_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
